acq_trigger_ctrl: RTL and testbench
===================================

# acq_trigger_ctrl

Sequences ADC sample capture into the LVDS sample FIFO in the `clklvds` domain, replacing the free-running trigger counter. On `arm` it fills a pre-trigger window, then holds that window by dropping the oldest sample for each new one. On a threshold-crossing, auto-timeout or forced trigger it writes the post-trigger samples and reports done to the command processor.

## Interface
- `SAMPLE_W`, 10: trigger-channel sample width (unsigned)
- `LEN_W`, 16: width of the pre/post/timeout length fields
- `FIFO_AW`, 11: width of `fifo_wrused`
- `FIFO_HIGH`, 1020: writes are stalled when `fifo_wrused >= FIFO_HIGH`

Ports:
- `clk`  in  1  sample clock (LVDS bit rate / 2)
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `arm`  in  1  start-acquisition pulse
- `abort`  in  1  return to IDLE
- `pre_len`  in  LEN_W  pre-trigger sample count; latched on accepted `arm`
- `post_len`  in  LEN_W  post-trigger sample count, trigger sample included; latched on `arm`
- `trig_mode`  in  2  0 normal, 1 auto, 2 force, 3 = normal; latched on `arm`
- `trig_edge`  in  1  0 rising, 1 falling; latched on `arm`
- `threshold`  in  SAMPLE_W  trigger level; latched on `arm`
- `auto_timeout`  in  LEN_W  ARMED cycles before auto trigger; latched on `arm`
- `sample`  in  SAMPLE_W  trigger-channel sample, valid every cycle
- `fifo_wrused`  in  FIFO_AW  FIFO fill level
- `fifo_wr`  out  1  FIFO write strobe
- `fifo_drop`  out  1  FIFO read strobe that discards the oldest sample
- `busy`  out  1  state is PRETRIG, ARMED or POSTTRIG
- `done`  out  1  level, high in DONE
- `triggered`  out  1  one-cycle pulse when the trigger is taken
- `overrun`  out  1  sticky; a write was stalled because the FIFO was full; cleared on `arm`
- `armed_cycles`  out  32  clocks spent in ARMED, saturating at all-ones; cleared on `arm`

## Operation
- States: IDLE, PRETRIG, ARMED, POSTTRIG, DONE.
- Write intent is high in PRETRIG, ARMED and POSTTRIG.
  - `fifo_wr` is asserted only when write intent is high and `fifo_wrused < FIFO_HIGH`.
  - If write intent is high and `fifo_wrused >= FIFO_HIGH`: no write, set `overrun`, the sample is lost, counters do not advance.
- IDLE or DONE, and `arm` with no `abort`: latch the configuration and clear the counters.
  - Go to PRETRIG if `pre_len != 0`, otherwise to ARMED.
  - `arm` is ignored while `busy`.
- PRETRIG: count writes. When the write count reaches `pre_len`, go to ARMED on the same edge as the last write.
- ARMED:
  - Every write is paired with `fifo_drop=1` when `pre_len != 0`, so FIFO occupancy from this block stays at `pre_len`.
  - `armed_cycles` increments every cycle.
  - Trigger conditions:
    - Rising: `prev < threshold && sample >= threshold`.
    - Falling: `prev >= threshold && sample < threshold`.
    - `prev` is the previous cycle's sample. `prev` is invalid on the first ARMED cycle, and no edge can fire that cycle.
    - Force: trigger on the first ARMED cycle.
    - Auto: edge trigger, or `armed_cycles == auto_timeout`; `auto_timeout == 0` triggers immediately.
  - On trigger: pulse `triggered`, go to POSTTRIG. No `fifo_drop` that cycle. The trigger sample counts as post sample 1.
- POSTTRIG: count writes up to max(`post_len`, 1), then go to DONE. The trigger sample counts toward this.
- DONE: no writes, `done=1`, hold until `arm` or `abort`.
- `abort` in any state goes to IDLE next cycle: `fifo_wr`/`fifo_drop` low next cycle, no FIFO flush (the consumer flushes). If `arm` and `abort` occur together, `abort` wins.

## Timing
- Reset values: state IDLE; all outputs 0; `armed_cycles` 0; latched configuration 0.
- All outputs are registered.
  - `fifo_wr` in cycle k qualifies the LVDS word the top level registered on the edge that began cycle k.
  - The top-level data register stays free-running.
- Latency:
  - `arm` sampled at edge N → `busy` and first `fifo_wr` in cycle N+1.
  - Trigger sample at edge T → `triggered` and the POSTTRIG state in cycle T+1, with that sample's write in the same cycle.
- The last post-trigger write and `done` are separated by exactly one cycle.
- Counters are LEN_W wide, compared with ==, and never wrap, because they stop at their limit.
- `rst` mid-acquisition takes effect on the next edge: all outputs return to their reset values and the FIFO contents are left as-is.

## Structure
- Package `acq_pkg`:
  - state enum
  - `trig_mode` constants (NORMAL, AUTO, FORCE)
  - default `FIFO_HIGH`
- Sub-module `acq_trig_detect`: `prev` register, prev-valid flag, and edge/threshold comparison. It has its own clear input, driven on ARMED entry.
- The top level holds the FSM, counters, the FIFO stall gate and the status flags.

## Test plan
- Normal trigger: `pre_len=4`, `post_len=8`, rising, `threshold=512`, ramp 500→520 in steps of 1.
  - `triggered` is high one cycle after the sample equal to 512.
  - Exactly 4 writes before the trigger, and 8 from the trigger sample onward.
  - `fifo_drop` count equals ARMED writes minus 1.
  - `done` is high one cycle after the last write.
- Auto mode with a constant sample of 100, `auto_timeout=20`: trigger when `armed_cycles==20`; `armed_cycles` holds 21 in DONE.
- Force, `pre_len=0`, `post_len=0`:
  - Trigger on the first ARMED cycle, exactly 1 write.
  - `fifo_drop` never asserted.
  - `done` 3 cycles after `arm`.
- FIFO full: hold `fifo_wrused=1020` for 5 cycles during POSTTRIG → no writes in those cycles, `overrun=1`, total post writes still equal `post_len`.
- Abort and arm together while in ARMED → IDLE next cycle, `fifo_wr=0`, `busy=0`. A later `arm` restarts cleanly and clears `overrun`.
- `rst` asserted during POSTTRIG → next cycle all outputs are 0 and state is IDLE; `arm` while `busy` is ignored.

Source files
------------

// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared types and constants for the acquisition trigger sequencer
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRETRIG,
        ST_ARMED,
        ST_POSTTRIG,
        ST_DONE
    } acq_state_t;

    localparam logic [1:0] TRIG_NORMAL = 2'd0;
    localparam logic [1:0] TRIG_AUTO   = 2'd1;
    localparam logic [1:0] TRIG_FORCE  = 2'd2;

    localparam int FIFO_HIGH_DEFAULT = 1020;

endpackage

// File: rtl/acq_fifo_if.sv
// rtl/acq_fifo_if.sv - write/drop strobes and fill level between sequencer and sample FIFO
interface acq_fifo_if #(
    parameter int FIFO_AW = 11
);
    logic               fifo_wr;
    logic               fifo_drop;
    logic [FIFO_AW-1:0] fifo_wrused;

    modport master (output fifo_wr, output fifo_drop, input fifo_wrused);
    modport slave  (input fifo_wr, input fifo_drop, output fifo_wrused);
endinterface

// File: rtl/acq_trig_detect.sv
// rtl/acq_trig_detect.sv - previous-sample register and threshold crossing detector
module acq_trig_detect #(
    parameter int SAMPLE_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                falling,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] threshold,
    output logic                hit
);
    logic [SAMPLE_W-1:0] prev;
    logic                prev_valid;

    // clr marks the next cycle's prev as stale so no edge fires on the first ARMED cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev       <= sample;
            prev_valid <= ~clr;
        end
    end

    always_comb begin
        if (falling) begin
            hit = prev_valid && (prev >= threshold) && (sample < threshold);
        end else begin
            hit = prev_valid && (prev < threshold) && (sample >= threshold);
        end
    end
endmodule

// File: rtl/acq_trigger_ctrl.sv
// rtl/acq_trigger_ctrl.sv - ADC capture sequencer: pre-trigger window, trigger, post-trigger fill
module acq_trigger_ctrl
    import acq_pkg::*;
#(
    parameter int SAMPLE_W  = 10,
    parameter int LEN_W     = 16,
    parameter int FIFO_AW   = 11,
    parameter int FIFO_HIGH = FIFO_HIGH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                abort,
    input  logic [LEN_W-1:0]    pre_len,
    input  logic [LEN_W-1:0]    post_len,
    input  logic [1:0]          trig_mode,
    input  logic                trig_edge,
    input  logic [SAMPLE_W-1:0] threshold,
    input  logic [LEN_W-1:0]    auto_timeout,
    input  logic [SAMPLE_W-1:0] sample,
    acq_fifo_if.master          fifo,
    output logic                busy,
    output logic                done,
    output logic                triggered,
    output logic                overrun,
    output logic [31:0]         armed_cycles
);
    localparam logic [FIFO_AW-1:0] HIGH_LVL = FIFO_AW'(FIFO_HIGH);

    acq_state_t          state, state_n;
    logic [LEN_W-1:0]    cnt, cnt_n;
    logic [LEN_W-1:0]    pre_q, post_q, timeout_q, post_target;
    logic [1:0]          mode_q;
    logic                fall_q;
    logic [SAMPLE_W-1:0] thr_q;
    logic                fifo_wr_q, fifo_drop_q;
    logic                room, intent, drop_req, accept, fire, edge_hit, trig_clr;
    logic                wr_n, drop_n, trig_n, stall;

    acq_trig_detect #(.SAMPLE_W(SAMPLE_W)) u_detect (
        .clk       (clk),
        .rst       (rst),
        .clr       (trig_clr),
        .falling   (fall_q),
        .sample    (sample),
        .threshold (thr_q),
        .hit       (edge_hit)
    );

    assign room        = fifo.fifo_wrused < HIGH_LVL;
    assign post_target = (post_q == '0) ? LEN_W'(1) : post_q;

    // armed_cycles is cleared on arm and ARMED is entered once per run, so zero means first cycle
    always_comb begin
        case (mode_q)
            TRIG_AUTO:  fire = edge_hit || (armed_cycles == 32'(timeout_q));
            TRIG_FORCE: fire = (armed_cycles == 32'd0);
            default:    fire = edge_hit;
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        intent   = 1'b0;
        drop_req = 1'b0;
        accept   = 1'b0;
        trig_n   = 1'b0;
        trig_clr = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    accept = 1'b1;
                    cnt_n  = '0;
                    if (pre_len == '0) begin
                        state_n  = ST_ARMED;
                        trig_clr = 1'b1;
                    end else begin
                        intent  = 1'b1;
                        state_n = ST_PRETRIG;
                        if (room) begin
                            cnt_n = LEN_W'(1);
                            if (pre_len == LEN_W'(1)) begin
                                state_n  = ST_ARMED;
                                trig_clr = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_PRETRIG: begin
                intent = 1'b1;
                if (room) begin
                    cnt_n = cnt + LEN_W'(1);
                    if (cnt_n == pre_q) begin
                        state_n  = ST_ARMED;
                        trig_clr = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (fire) begin
                    trig_n  = 1'b1;
                    intent  = 1'b1;
                    state_n = ST_POSTTRIG;
                    cnt_n   = room ? LEN_W'(1) : '0;
                end else begin
                    // with an empty window a write+drop pair would be a no-op, so skip both
                    intent   = (pre_q != '0);
                    drop_req = 1'b1;
                end
            end
            ST_POSTTRIG: begin
                if (cnt == post_target) begin
                    state_n = ST_DONE;
                end else begin
                    intent = 1'b1;
                    if (room) cnt_n = cnt + LEN_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (abort) begin
            state_n  = ST_IDLE;
            intent   = 1'b0;
            accept   = 1'b0;
            trig_n   = 1'b0;
            trig_clr = 1'b0;
        end
        wr_n   = intent && room;
        drop_n = wr_n && drop_req;
        stall  = intent && !room;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            pre_q        <= '0;
            post_q       <= '0;
            timeout_q    <= '0;
            mode_q       <= '0;
            fall_q       <= 1'b0;
            thr_q        <= '0;
            fifo_wr_q    <= 1'b0;
            fifo_drop_q  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            triggered    <= 1'b0;
            overrun      <= 1'b0;
            armed_cycles <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            fifo_wr_q   <= wr_n;
            fifo_drop_q <= drop_n;
            triggered   <= trig_n;
            busy        <= (state_n == ST_PRETRIG) || (state_n == ST_ARMED) || (state_n == ST_POSTTRIG);
            done        <= (state_n == ST_DONE);
            if (accept) begin
                pre_q        <= pre_len;
                post_q       <= post_len;
                timeout_q    <= auto_timeout;
                mode_q       <= trig_mode;
                fall_q       <= trig_edge;
                thr_q        <= threshold;
                overrun      <= stall;
                armed_cycles <= '0;
            end else begin
                overrun <= overrun | stall;
                if ((state == ST_ARMED) && (armed_cycles != '1)) begin
                    armed_cycles <= armed_cycles + 32'd1;
                end
            end
        end
    end

    assign fifo.fifo_wr   = fifo_wr_q;
    assign fifo.fifo_drop = fifo_drop_q;
endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// tb/tb_acq_trigger_ctrl.sv - self-checking bench for acq_trigger_ctrl against a window/trigger model
module tb_acq_trigger_ctrl;
    localparam int MAXC = 64;

    logic        clk = 1'b0;
    logic        rst, arm, abort, trig_edge;
    logic [15:0] pre_len, post_len, auto_timeout;
    logic [1:0]  trig_mode;
    logic [9:0]  threshold, sample;
    logic        busy, done, triggered, overrun;
    logic [31:0] armed_cycles;

    acq_fifo_if #(.FIFO_AW(11)) fifo_bus ();

    acq_trigger_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .abort        (abort),
        .pre_len      (pre_len),
        .post_len     (post_len),
        .trig_mode    (trig_mode),
        .trig_edge    (trig_edge),
        .threshold    (threshold),
        .auto_timeout (auto_timeout),
        .sample       (sample),
        .fifo         (fifo_bus),
        .busy         (busy),
        .done         (done),
        .triggered    (triggered),
        .overrun      (overrun),
        .armed_cycles (armed_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int cfg_pre, cfg_post, cfg_mode, cfg_fall, cfg_thr, cfg_timeout;
    int sarr[MAXC];
    logic [MAXC-1:0] stall_v;
    logic [MAXC-1:0] obs_wr_v, obs_drop_v, obs_trig_v, obs_done_v, obs_busy_v;
    logic [MAXC-1:0] exp_wr_v, exp_drop_v, exp_trig_v, exp_done_v, exp_busy_v;
    logic [31:0] obs_ac;
    logic        obs_ovr;
    int          exp_ac, exp_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_set(input logic [MAXC-1:0] v);
        for (int i = 0; i < MAXC; i++) if (v[i]) return i;
        return -1;
    endfunction

    // arm is sampled at edge 0; bit e of each vector is the output in the cycle after edge e
    task automatic capture(input int ncyc);
        abort = 1'b1; arm = 1'b0; fifo_bus.fifo_wrused = 11'd0;
        step();
        abort        = 1'b0;
        pre_len      = 16'(cfg_pre);
        post_len     = 16'(cfg_post);
        trig_mode    = 2'(cfg_mode);
        trig_edge    = 1'(cfg_fall);
        threshold    = 10'(cfg_thr);
        auto_timeout = 16'(cfg_timeout);
        obs_wr_v = '0; obs_drop_v = '0; obs_trig_v = '0; obs_done_v = '0; obs_busy_v = '0;
        for (int e = 0; e < ncyc; e++) begin
            arm    = (e == 0);
            sample = 10'(sarr[e]);
            fifo_bus.fifo_wrused = stall_v[e] ? 11'd1020 : 11'd1019;
            step();
            obs_wr_v[e]   = fifo_bus.fifo_wr;
            obs_drop_v[e] = fifo_bus.fifo_drop;
            obs_trig_v[e] = triggered;
            obs_done_v[e] = done;
            obs_busy_v[e] = busy;
        end
        arm = 1'b0; fifo_bus.fifo_wrused = 11'd0;
        obs_ac  = armed_cycles;
        obs_ovr = overrun;
    endtask

    // Reference: the window occupies edges [0, trigger), trigger found by scanning the sample list
    task automatic model(input int ncyc);
        int   a, p, k, armed_end;
        logic edge_ok, fire;
        a     = (cfg_pre > 0) ? cfg_pre : 1;
        exp_t = -1;
        for (int t = a; t < ncyc && exp_t < 0; t++) begin
            k = t - a;
            edge_ok = (t > a) && (cfg_fall != 0 ? (sarr[t-1] >= cfg_thr && sarr[t] < cfg_thr)
                                                : (sarr[t-1] < cfg_thr && sarr[t] >= cfg_thr));
            case (cfg_mode)
                2:       fire = (k == 0);
                1:       fire = edge_ok || (k == cfg_timeout);
                default: fire = edge_ok;
            endcase
            if (fire) exp_t = t;
        end
        p         = (cfg_post == 0) ? 1 : cfg_post;
        armed_end = (exp_t < 0) ? ncyc : exp_t;
        exp_wr_v = '0; exp_drop_v = '0; exp_trig_v = '0; exp_done_v = '0; exp_busy_v = '0;
        for (int e = 0; e < ncyc; e++) begin
            exp_wr_v[e]   = (cfg_pre > 0 && e < armed_end) || (exp_t >= 0 && e >= exp_t && e < exp_t + p);
            exp_drop_v[e] = (cfg_pre > 0) && (e >= a) && (e < armed_end);
            exp_trig_v[e] = (e == exp_t);
            exp_done_v[e] = (exp_t >= 0) && (e >= exp_t + p);
            exp_busy_v[e] = !exp_done_v[e];
        end
        exp_ac = armed_end - a + ((exp_t >= 0) ? 1 : 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b0; abort = 1'b0; sample = '0; fifo_bus.fifo_wrused = '0;
        pre_len = '0; post_len = '0; trig_mode = '0; trig_edge = 1'b0; threshold = '0; auto_timeout = '0;
        step(); step();
        n_checks++;
        if ({fifo_bus.fifo_wr, fifo_bus.fifo_drop, busy, done, triggered, overrun} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000", {fifo_bus.fifo_wr, fifo_bus.fifo_drop, busy, done, triggered, overrun});
        else n_pass++;
        n_checks++;
        if (armed_cycles !== 32'd0) $display("FAIL reset_armed_cycles got %0d want 0", armed_cycles); else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_normal();
        cfg_pre = 4; cfg_post = 8; cfg_mode = 0; cfg_fall = 0; cfg_thr = 512; cfg_timeout = 0;
        stall_v = '0;
        for (int e = 0; e < MAXC; e++) sarr[e] = 500 + e;
        model(30);
        capture(30);
        n_checks++;
        if (obs_wr_v !== exp_wr_v) $display("FAIL normal_wr got %h want %h", obs_wr_v, exp_wr_v); else n_pass++;
        n_checks++;
        if (obs_drop_v !== exp_drop_v) $display("FAIL normal_drop got %h want %h", obs_drop_v, exp_drop_v); else n_pass++;
        n_checks++;
        if (first_set(obs_trig_v) !== 12) $display("FAIL normal_trig_edge got %0d want 12", first_set(obs_trig_v)); else n_pass++;
        n_checks++;
        if ($countones(obs_wr_v) - $countones(obs_drop_v) !== 12)
            $display("FAIL normal_net_writes got %0d want 12", $countones(obs_wr_v) - $countones(obs_drop_v));
        else n_pass++;
        n_checks++;
        if (first_set(obs_done_v) !== 20) $display("FAIL normal_done_edge got %0d want 20", first_set(obs_done_v)); else n_pass++;
    endtask

    task automatic test_auto();
        cfg_pre = 2; cfg_post = 3; cfg_mode = 1; cfg_fall = 0; cfg_thr = 512; cfg_timeout = 20;
        stall_v = '0;
        for (int e = 0; e < MAXC; e++) sarr[e] = 100;
        model(40);
        capture(40);
        n_checks++;
        if (obs_trig_v !== exp_trig_v) $display("FAIL auto_trig got %h want %h", obs_trig_v, exp_trig_v); else n_pass++;
        n_checks++;
        if (obs_wr_v !== exp_wr_v) $display("FAIL auto_wr got %h want %h", obs_wr_v, exp_wr_v); else n_pass++;
        n_checks++;
        if (obs_ac !== 32'd21) $display("FAIL auto_armed_cycles got %0d want 21", obs_ac); else n_pass++;
        n_checks++;
        if (obs_done_v[39] !== 1'b1) $display("FAIL auto_done got %b want 1", obs_done_v[39]); else n_pass++;
    endtask

    task automatic test_force();
        cfg_pre = 0; cfg_post = 0; cfg_mode = 2; cfg_fall = 0; cfg_thr = 300; cfg_timeout = 0;
        stall_v = '0;
        for (int e = 0; e < MAXC; e++) sarr[e] = int'($urandom_range(0, 1023));
        model(10);
        capture(10);
        n_checks++;
        if ($countones(obs_wr_v) !== 1) $display("FAIL force_writes got %0d want 1", $countones(obs_wr_v)); else n_pass++;
        n_checks++;
        if (obs_drop_v !== '0) $display("FAIL force_drop got %h want 0", obs_drop_v); else n_pass++;
        n_checks++;
        if (first_set(obs_trig_v) !== 1) $display("FAIL force_trig_edge got %0d want 1", first_set(obs_trig_v)); else n_pass++;
        n_checks++;
        if (first_set(obs_done_v) !== 2) $display("FAIL force_done_edge got %0d want 2", first_set(obs_done_v)); else n_pass++;
        n_checks++;
        if (obs_busy_v !== exp_busy_v) $display("FAIL force_busy got %h want %h", obs_busy_v, exp_busy_v); else n_pass++;
    endtask

    task automatic test_random();
        int s;
        for (int it = 0; it < 6; it++) begin
            cfg_pre     = int'($urandom_range(0, 6));
            cfg_post    = int'($urandom_range(0, 6));
            cfg_mode    = int'($urandom_range(0, 3));
            cfg_fall    = int'($urandom_range(0, 1));
            cfg_thr     = int'($urandom_range(200, 800));
            cfg_timeout = int'($urandom_range(0, 15));
            stall_v     = '0;
            s = cfg_thr + int'($urandom_range(0, 60)) - 30;
            for (int e = 0; e < MAXC; e++) begin
                sarr[e] = s;
                s = s + int'($urandom_range(0, 20)) - 10;
            end
            model(60);
            capture(60);
            n_checks++;
            if (obs_wr_v !== exp_wr_v) $display("FAIL rand%0d_wr got %h want %h", it, obs_wr_v, exp_wr_v); else n_pass++;
            n_checks++;
            if (obs_drop_v !== exp_drop_v) $display("FAIL rand%0d_drop got %h want %h", it, obs_drop_v, exp_drop_v); else n_pass++;
            n_checks++;
            if (obs_trig_v !== exp_trig_v) $display("FAIL rand%0d_trig got %h want %h", it, obs_trig_v, exp_trig_v); else n_pass++;
            n_checks++;
            if (obs_done_v !== exp_done_v) $display("FAIL rand%0d_done got %h want %h", it, obs_done_v, exp_done_v); else n_pass++;
            n_checks++;
            if (obs_ac !== 32'(exp_ac)) $display("FAIL rand%0d_armed_cycles got %0d want %0d", it, obs_ac, exp_ac); else n_pass++;
        end
    endtask

    task automatic test_fifo_full();
        cfg_pre = 2; cfg_post = 6; cfg_mode = 2; cfg_fall = 0; cfg_thr = 0; cfg_timeout = 0;
        for (int e = 0; e < MAXC; e++) sarr[e] = e;
        stall_v = '0;
        for (int e = 4; e < 9; e++) stall_v[e] = 1'b1;
        capture(20);
        n_checks++;
        if ((obs_wr_v & stall_v) !== '0) $display("FAIL full_stalled_writes got %h want 0", obs_wr_v & stall_v); else n_pass++;
        n_checks++;
        if ($countones(obs_wr_v) !== 8) $display("FAIL full_total_writes got %0d want 8", $countones(obs_wr_v)); else n_pass++;
        n_checks++;
        if (obs_ovr !== 1'b1) $display("FAIL full_overrun got %b want 1", obs_ovr); else n_pass++;
        n_checks++;
        if (first_set(obs_done_v) !== 13) $display("FAIL full_done_edge got %0d want 13", first_set(obs_done_v)); else n_pass++;
        stall_v = '0;
    endtask

    task automatic test_abort_arm();
        cfg_pre = 3; cfg_post = 4; cfg_mode = 0; cfg_fall = 0; cfg_thr = 900; cfg_timeout = 0;
        for (int e = 0; e < MAXC; e++) sarr[e] = 10;
        stall_v = '0; stall_v[1] = 1'b1;
        capture(8);
        stall_v = '0;
        n_checks++;
        if (obs_wr_v[1] !== 1'b0 || obs_ovr !== 1'b1)
            $display("FAIL abort_setup got wr=%b ovr=%b want wr=0 ovr=1", obs_wr_v[1], obs_ovr);
        else n_pass++;
        arm = 1'b1; abort = 1'b1; sample = 10'd10;
        step();
        arm = 1'b0; abort = 1'b0;
        n_checks++;
        if ({fifo_bus.fifo_wr, fifo_bus.fifo_drop, busy, done} !== 4'b0)
            $display("FAIL abort_outputs got %b want 0000", {fifo_bus.fifo_wr, fifo_bus.fifo_drop, busy, done});
        else n_pass++;
        step();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_stays_idle got %b want 0", busy); else n_pass++;
        cfg_pre = 1; cfg_post = 2; cfg_mode = 2;
        model(10);
        capture(10);
        n_checks++;
        if (obs_wr_v !== exp_wr_v) $display("FAIL rearm_wr got %h want %h", obs_wr_v, exp_wr_v); else n_pass++;
        n_checks++;
        if (obs_done_v !== exp_done_v) $display("FAIL rearm_done got %h want %h", obs_done_v, exp_done_v); else n_pass++;
        n_checks++;
        if (obs_ovr !== 1'b0) $display("FAIL rearm_overrun got %b want 0", obs_ovr); else n_pass++;
    endtask

    task automatic test_rst_mid();
        cfg_pre = 1; cfg_post = 20; cfg_mode = 2; cfg_fall = 0; cfg_thr = 0; cfg_timeout = 0;
        stall_v = '0;
        for (int e = 0; e < MAXC; e++) sarr[e] = 3 * e;
        capture(5);
        pre_len = 16'd4;
        arm = 1'b1;
        step();
        arm = 1'b0;
        n_checks++;
        if (armed_cycles !== 32'd1 || busy !== 1'b1 || triggered !== 1'b0)
            $display("FAIL busy_arm_ignored got ac=%0d busy=%b trig=%b want ac=1 busy=1 trig=0", armed_cycles, busy, triggered);
        else n_pass++;
        rst = 1'b1;
        step();
        n_checks++;
        if ({fifo_bus.fifo_wr, fifo_bus.fifo_drop, busy, done, triggered, overrun} !== 6'b0)
            $display("FAIL rst_mid_flags got %b want 000000", {fifo_bus.fifo_wr, fifo_bus.fifo_drop, busy, done, triggered, overrun});
        else n_pass++;
        n_checks++;
        if (armed_cycles !== 32'd0) $display("FAIL rst_mid_armed_cycles got %0d want 0", armed_cycles); else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || fifo_bus.fifo_wr !== 1'b0)
            $display("FAIL rst_mid_idle got busy=%b wr=%b want 0 0", busy, fifo_bus.fifo_wr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_auto();
        test_force();
        test_random();
        test_fifo_full();
        test_abort_arm();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
